// File: rtl/alarm_buzzer_driver_if.sv
// Buzzer driver signal bundle: PIO alarm request in, buzzer drive and status out.
// Master is the PIO/CPU side, slave is the buzzer driver.
interface alarm_buzzer_driver_if;
    logic enable;
    logic buzzer_out;
    logic active;
    logic burst_done;
    logic timed_out;

    modport master (
        output enable,
        input  buzzer_out,
        input  active,
        input  burst_done,
        input  timed_out
    );

    modport slave (
        input  enable,
        output buzzer_out,
        output active,
        output burst_done,
        output timed_out
    );
endinterface

// File: rtl/alarm_buzzer_driver.sv
// Alarm buzzer driver: PIO level bit -> gated square-wave beep/beep/pause cadence; BUZZER_TIMEOUT_EN adds auto-silence (HOLD).
// Latency: enable rise to first high buzzer_out is 1 cycle; no backpressure, enable low returns to IDLE at the next edge.
module alarm_buzzer_driver #(
    parameter int TONE_HALF  = 12500,
    parameter int ON_CYCLES  = 5000000,
    parameter int OFF_CYCLES = 2500000,
    parameter int BEEPS      = 3,
    parameter int GAP_CYCLES = 25000000,
    parameter int MAX_BURSTS = 60
) (
    input  logic                   clk,
    input  logic                   reset,
    alarm_buzzer_driver_if.slave   bus
);

    localparam int TN_W = $clog2(TONE_HALF + 1);
    localparam int ON_W = $clog2(ON_CYCLES + 1);
    localparam int OF_W = $clog2(OFF_CYCLES + 1);
    localparam int GP_W = $clog2(GAP_CYCLES + 1);
    localparam int BI_W = $clog2(BEEPS + 1);

    localparam logic [TN_W-1:0] TN_LOAD = TN_W'(TONE_HALF - 1);
    localparam logic [ON_W-1:0] ON_LOAD = ON_W'(ON_CYCLES - 1);
    localparam logic [OF_W-1:0] OF_LOAD = OF_W'(OFF_CYCLES - 1);
    localparam logic [GP_W-1:0] GP_LOAD = GP_W'(GAP_CYCLES - 1);
    localparam logic [BI_W-1:0] BI_LAST = BI_W'(BEEPS - 1);

    localparam logic [TN_W-1:0] TN_ONE = 1;
    localparam logic [ON_W-1:0] ON_ONE = 1;
    localparam logic [OF_W-1:0] OF_ONE = 1;
    localparam logic [GP_W-1:0] GP_ONE = 1;
    localparam logic [BI_W-1:0] BI_ONE = 1;

`ifdef BUZZER_TIMEOUT_EN
    localparam int BU_W = $clog2(MAX_BURSTS + 1);
    localparam logic [BU_W-1:0] BU_MAX = BU_W'(MAX_BURSTS);
    localparam logic [BU_W-1:0] BU_ONE = 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_BEEP_ON, ST_BEEP_OFF, ST_GAP, ST_HOLD
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_IDLE, ST_BEEP_ON, ST_BEEP_OFF, ST_GAP
    } state_t;
`endif

    state_t          state_q,    state_d;
    logic [TN_W-1:0] tone_cnt_q, tone_cnt_d;
    logic [ON_W-1:0] on_cnt_q,   on_cnt_d;
    logic [OF_W-1:0] off_cnt_q,  off_cnt_d;
    logic [GP_W-1:0] gap_cnt_q,  gap_cnt_d;
    logic [BI_W-1:0] beep_idx_q, beep_idx_d;
    logic            buzz_q,     buzz_d;
    logic            active_q,   active_d;
    logic            done_q,     done_d;
`ifdef BUZZER_TIMEOUT_EN
    logic [BU_W-1:0] burst_q,    burst_d;
    logic [BU_W-1:0] burst_inc;
    logic            tmo_q,      tmo_d;
`endif

    always_comb begin
        state_d    = state_q;
        tone_cnt_d = tone_cnt_q;
        on_cnt_d   = on_cnt_q;
        off_cnt_d  = off_cnt_q;
        gap_cnt_d  = gap_cnt_q;
        beep_idx_d = beep_idx_q;
        buzz_d     = 1'b0;
        active_d   = 1'b0;
        done_d     = 1'b0;
`ifdef BUZZER_TIMEOUT_EN
        burst_d    = burst_q;
        tmo_d      = 1'b0;
        burst_inc  = (burst_q == BU_MAX) ? burst_q : burst_q + BU_ONE;
`endif

        if (state_q != ST_IDLE && !bus.enable) begin
            // Dropping the request aborts immediately, mid-beep included.
            state_d    = ST_IDLE;
            tone_cnt_d = '0;
            on_cnt_d   = '0;
            off_cnt_d  = '0;
            gap_cnt_d  = '0;
            beep_idx_d = '0;
`ifdef BUZZER_TIMEOUT_EN
            burst_d    = '0;
`endif
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (bus.enable) begin
                        state_d    = ST_BEEP_ON;
                        on_cnt_d   = ON_LOAD;
                        tone_cnt_d = TN_LOAD;
                        buzz_d     = 1'b1;
                        active_d   = 1'b1;
                    end
                end

                ST_BEEP_ON: begin
                    active_d = 1'b1;
                    if (on_cnt_q == '0) begin
                        if (beep_idx_q < BI_LAST) begin
                            state_d    = ST_BEEP_OFF;
                            off_cnt_d  = OF_LOAD;
                            beep_idx_d = beep_idx_q + BI_ONE;
                        end else begin
                            state_d    = ST_GAP;
                            gap_cnt_d  = GP_LOAD;
                            beep_idx_d = '0;
                            done_d     = (GP_LOAD == '0);
                        end
                    end else begin
                        on_cnt_d = on_cnt_q - ON_ONE;
                        if (tone_cnt_q == '0) begin
                            tone_cnt_d = TN_LOAD;
                            buzz_d     = ~buzz_q;
                        end else begin
                            tone_cnt_d = tone_cnt_q - TN_ONE;
                            buzz_d     = buzz_q;
                        end
                    end
                end

                ST_BEEP_OFF: begin
                    active_d = 1'b1;
                    if (off_cnt_q == '0) begin
                        state_d    = ST_BEEP_ON;
                        on_cnt_d   = ON_LOAD;
                        tone_cnt_d = TN_LOAD;
                        buzz_d     = 1'b1;
                    end else begin
                        off_cnt_d = off_cnt_q - OF_ONE;
                    end
                end

                ST_GAP: begin
                    active_d = 1'b1;
                    if (gap_cnt_q == '0) begin
`ifdef BUZZER_TIMEOUT_EN
                        burst_d = burst_inc;
                        if (burst_inc == BU_MAX) begin
                            state_d  = ST_HOLD;
                            active_d = 1'b0;
                            tmo_d    = 1'b1;
                        end else begin
                            state_d    = ST_BEEP_ON;
                            on_cnt_d   = ON_LOAD;
                            tone_cnt_d = TN_LOAD;
                            buzz_d     = 1'b1;
                        end
`else
                        state_d    = ST_BEEP_ON;
                        on_cnt_d   = ON_LOAD;
                        tone_cnt_d = TN_LOAD;
                        buzz_d     = 1'b1;
`endif
                    end else begin
                        gap_cnt_d = gap_cnt_q - GP_ONE;
                        // Registered pulse must land in the last GAP cycle.
                        done_d    = (gap_cnt_q == GP_ONE);
                    end
                end

`ifdef BUZZER_TIMEOUT_EN
                ST_HOLD: begin
                    tmo_d = 1'b1;
                end
`endif

                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tone_cnt_q <= '0;
            on_cnt_q   <= '0;
            off_cnt_q  <= '0;
            gap_cnt_q  <= '0;
            beep_idx_q <= '0;
            buzz_q     <= 1'b0;
            active_q   <= 1'b0;
            done_q     <= 1'b0;
`ifdef BUZZER_TIMEOUT_EN
            burst_q    <= '0;
            tmo_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            tone_cnt_q <= tone_cnt_d;
            on_cnt_q   <= on_cnt_d;
            off_cnt_q  <= off_cnt_d;
            gap_cnt_q  <= gap_cnt_d;
            beep_idx_q <= beep_idx_d;
            buzz_q     <= buzz_d;
            active_q   <= active_d;
            done_q     <= done_d;
`ifdef BUZZER_TIMEOUT_EN
            burst_q    <= burst_d;
            tmo_q      <= tmo_d;
`endif
        end
    end

    assign bus.buzzer_out = buzz_q;
    assign bus.active     = active_q;
    assign bus.burst_done = done_q;
`ifdef BUZZER_TIMEOUT_EN
    assign bus.timed_out  = tmo_q;
`else
    assign bus.timed_out  = 1'b0;
`endif

endmodule

// File: doc/alarm_buzzer_driver.md
Name: alarm_buzzer_driver

Overview:
- Sits directly downstream of the CPU's single-bit buzzer PIO output register.
- Converts the PIO's level "alarm on" bit into an audible drive signal for the piezo buzzer pin: square-wave tone, gated into a beep/beep/pause cadence.
- Purely sequential: tone divider, cadence FSM and burst counter, all in the CPU clock domain.
- The software-visible register stays a plain on/off bit.

Parameters:
- TONE_HALF, 12500: clk cycles per tone half-period (2 kHz at 50 MHz); min 1.
- ON_CYCLES, 5000000: clk cycles per beep (100 ms); min 1.
- OFF_CYCLES, 2500000: silent cycles between beeps within a burst; min 1.
- BEEPS, 3: beeps per burst; min 1.
- GAP_CYCLES, 25000000: silent cycles after the last beep of a burst; min 1.
- MAX_BURSTS, 60: completed bursts before auto-silence; used only with BUZZER_TIMEOUT_EN; min 1.

Ports:
- clk  input  1  system clock, same domain as the PIO.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  alarm request, driven by the buzzer PIO's out_port.
- buzzer_out  output  1  registered tone drive to the buzzer pin.
- active  output  1  registered; 1 when the FSM is not in IDLE or HOLD.
- burst_done  output  1  registered one-cycle pulse in the last GAP cycle of each burst.
- timed_out  output  1  registered; 1 while in HOLD; constant 0 without BUZZER_TIMEOUT_EN.

Behaviour:
- One clock; reset is synchronous and active-high, sampled on posedge clk.
- Reset has priority over all other inputs.
- Reset values: state=IDLE, buzzer_out=0, active=0, burst_done=0, timed_out=0, all counters 0.
- Counters: width $clog2(param+1). Duration counters load on state entry and count down. Beep and burst counters count up.
- FSM states: IDLE, BEEP_ON, BEEP_OFF, GAP, HOLD (HOLD only with the macro).
- IDLE:
  - enable=1 at a clock edge -> BEEP_ON at that edge; buzzer_out=1 and active=1 from that same edge.
  - Latency from the enable rise to the first high buzzer_out is 1 cycle.
- BEEP_ON:
  - Lasts exactly ON_CYCLES cycles.
  - The tone counter restarts on every entry; buzzer_out starts at 1 and toggles every TONE_HALF cycles.
  - On exit, if beep_idx < BEEPS-1 -> BEEP_OFF and beep_idx++. Otherwise -> GAP and beep_idx=0.
- BEEP_OFF: lasts exactly OFF_CYCLES; buzzer_out=0; then -> BEEP_ON.
- GAP:
  - Lasts exactly GAP_CYCLES; buzzer_out=0.
  - burst_done=1 during its final cycle only.
  - Then -> BEEP_ON, with the burst counter incremented (saturating).
- enable=0 in any state except IDLE: at the next edge -> IDLE, buzzer_out=0, active=0, all counters cleared. There is no completion of the current beep.
- Re-assertion of enable always restarts the cadence from the first beep.
- A glitch where enable is high for a single cycle produces exactly 1 cycle of buzzer_out=1, then IDLE.
- Reset asserted mid-beep: all outputs are at reset values after that edge. Nothing carries over.
- BEEPS=1: BEEP_OFF is never entered; BEEP_ON goes directly to GAP.
- TONE_HALF >= ON_CYCLES: buzzer_out stays 1 for the whole beep.

Optional Feature:
- Macro: BUZZER_TIMEOUT_EN.
- Defined:
  - When the burst counter reaches MAX_BURSTS, the final GAP exits to HOLD instead of BEEP_ON.
  - In HOLD: buzzer_out=0, active=0, timed_out=1.
  - Leaves HOLD -> IDLE only when enable=0; timed_out clears at that edge. Reset also clears it.
  - Continuous enable=1 never restarts the cadence from HOLD.
- Undefined:
  - HOLD and the burst counter are not synthesized; timed_out is tied to 0.
  - Bursts repeat indefinitely while enable=1.

Test Plan:
Bench parameters: TONE_HALF=2, ON_CYCLES=8, OFF_CYCLES=4, BEEPS=2, GAP_CYCLES=6, MAX_BURSTS=2. Cycle 1 is the first cycle after enable is sampled high.
1. Reset, then enable held 1 -> cycles 1-8 buzzer_out 1,1,0,0,1,1,0,0; cycles 9-12 =0; cycles 13-20 repeat the tone; cycles 21-26 =0 with burst_done=1 only at 26; cycle 27 buzzer_out=1; active=1 throughout.
2. Enable 1 for cycles 1-5, then 0 -> buzzer_out=0 and active=0 from cycle 6; re-enable at cycle 10 -> the full pattern of test 1 restarts with no residual beep count.
3. Reset pulsed at cycle 4 with enable held 1 -> at cycle 5 all outputs=0 and state=IDLE; the next sampled enable restarts at BEEP_ON with buzzer_out=1.
4. Enable pulsed for 1 cycle -> exactly one cycle buzzer_out=1, active=1; then IDLE, burst_done never asserted.
5. With BUZZER_TIMEOUT_EN and enable held 1 -> two burst_done pulses, at cycles 26 and 52; from cycle 53 buzzer_out=0, active=0, timed_out=1 held; enable low -> timed_out=0 at the next edge; enable high again -> new pattern.
6. Without BUZZER_TIMEOUT_EN, same stimulus as test 5 -> third burst starts at cycle 53 with buzzer_out=1; timed_out stays 0.
